exp4_unidade_controle: RTL and testbench
========================================

EXP4_UNIDADE_CONTROLE -- requirements
Module: exp4_unidade_controle

Interface
REQ-001 The parameter TIMEOUT_CICLOS SHALL default to 5000 and set the clock cycles allowed per play in ESPERA, range 2..65535.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately, independent of clock.
REQ-004 iniciar  input  1  start request, level-sampled each clock.
REQ-005 chaves  input  4  raw player keys, asynchronous to clock.
REQ-006 chavesIgualMemoria  input  1  datapath compare result, registered keys equal to memory word.
REQ-007 fimC  input  1  datapath address counter at last address 15.
REQ-008 zeraC, contaC, zeraR, registraR  output  1 each  datapath controls: clear counter, increment counter, clear register, load register.
REQ-009 pronto  output  1  game finished, any outcome.
REQ-010 acertou  output  1  all 16 plays matched.
REQ-011 errou  output  1  mismatch or timeout.
REQ-012 timeout  output  1  game ended by timeout.
REQ-013 db_estado  output  4  current state code, debug.

Function
REQ-014 Input path SHALL pass OR of chaves through a 2-flop synchronizer plus one history flop; jogada_feita = synchronized 1 AND history 0, a one-cycle pulse 3 clocks after the first key press.
REQ-015 Holding keys SHALL produce no further pulses until all keys are 0 for at least one synchronized cycle.
REQ-016 States and db_estado codes: INICIAL 0, PREPARACAO 1, ESPERA 2, REGISTRA 4, COMPARACAO 5, PROXIMO 6, FIM_ACERTOU A, FIM_TIMEOUT D, FIM_ERROU E; unused codes SHALL go to INICIAL.
REQ-017 INICIAL: iniciar=1 -> PREPARACAO, else hold.
REQ-018 PREPARACAO: zeraC=1, zeraR=1 -> ESPERA unconditionally.
REQ-019 ESPERA: jogada_feita=1 -> REGISTRA; else timer reaches TIMEOUT_CICLOS-1 -> FIM_TIMEOUT; else hold. If both occur in the same cycle, jogada_feita SHALL win.
REQ-020 REGISTRA: registraR=1 -> COMPARACAO.
REQ-021 COMPARACAO: chavesIgualMemoria=0 -> FIM_ERROU; =1 and fimC=1 -> FIM_ACERTOU; =1 and fimC=0 -> PROXIMO.
REQ-022 PROXIMO: contaC=1 -> ESPERA; the ESPERA dwell SHALL cover the synchronous ROM read latency.
REQ-023 FIM_* states: pronto=1; FIM_ACERTOU acertou=1; FIM_ERROU errou=1; FIM_TIMEOUT errou=1, timeout=1; iniciar=1 -> PREPARACAO, else hold.
REQ-024 All outputs SHALL be Moore, decoded from state only, and 0 where not stated.
REQ-025 Timeout timer SHALL be 16 bits, cleared on every cycle not in ESPERA, +1 per cycle in ESPERA, and never wrap.
REQ-026 iniciar SHALL be ignored in ESPERA, REGISTRA, COMPARACAO and PROXIMO.

Reset
REQ-027 reset=0 SHALL force INICIAL, timer 0, synchronizer and history flops 0, and all outputs 0 with db_estado=0, asynchronously, including mid-game.
REQ-028 After reset release, first transition SHALL occur no earlier than the next rising edge with iniciar=1.

Verification
REQ-029 Reset, iniciar pulse, then 16 presses each matching (chavesIgualMemoria=1, fimC=1 on 16th) -> contaC pulses 15 times; state A; pronto=1, acertou=1, errou=0.
REQ-030 Third press with chavesIgualMemoria=0 -> state E; pronto=1, errou=1, timeout=0; contaC pulsed exactly 2 times.
REQ-031 TIMEOUT_CICLOS=20, no key after PREPARACAO -> FIM_TIMEOUT after 20 cycles in ESPERA; errou=1, timeout=1, db_estado=D.
REQ-032 Key held 50 cycles in ESPERA -> exactly one registraR pulse; no second pulse until release and re-press.
REQ-033 reset=0 asserted in COMPARACAO between edges -> outputs 0 and db_estado=0 before the next edge; stays INICIAL until iniciar.
REQ-034 From state E, iniciar=1 -> PREPARACAO with zeraC=1 and zeraR=1 for one cycle, then ESPERA with timer 0.

Source files
------------

// File: rtl/exp4_unidade_controle.sv
// Control FSM for the 16-play memory game: sequences clear/count/register strobes and reports the outcome.
// Latency: key press reaches the FSM as a one-cycle pulse 3 clocks after the key goes high; outputs are Moore.
// Backpressure: none; a held key produces a single play until every key has been released.
module exp4_unidade_controle #(
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    input  logic       chavesIgualMemoria,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERROU   = 4'hE
    } estado_t;

    localparam logic [15:0] TIMER_LIMITE = 16'(TIMEOUT_CICLOS - 1);
    localparam logic [15:0] TIMER_MAX    = 16'hFFFF;

    estado_t     estado;
    estado_t     proximo_estado;
    logic        sinc1;
    logic        sinc2;
    logic        historico;
    logic        jogada_feita;
    logic [15:0] timer;
    logic        fim_tempo;

    // Keys are asynchronous: synchronise their OR, then edge-detect against one history flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc1     <= 1'b0;
            sinc2     <= 1'b0;
            historico <= 1'b0;
        end else begin
            sinc1     <= |chaves;
            sinc2     <= sinc1;
            historico <= sinc2;
        end
    end

    assign jogada_feita = sinc2 & ~historico;

    // Timer only runs while waiting for a play and saturates instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= 16'd0;
        end else if (estado != ESPERA) begin
            timer <= 16'd0;
        end else if (timer != TIMER_MAX) begin
            timer <= timer + 16'd1;
        end
    end

    assign fim_tempo = (timer == TIMER_LIMITE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo_estado;
        end
    end

    always_comb begin
        proximo_estado = estado;
        case (estado)
            INICIAL:     if (iniciar) proximo_estado = PREPARACAO;
            PREPARACAO:  proximo_estado = ESPERA;
            // A play arriving on the timeout cycle still counts.
            ESPERA: begin
                if (jogada_feita) begin
                    proximo_estado = REGISTRA;
                end else if (fim_tempo) begin
                    proximo_estado = FIM_TIMEOUT;
                end
            end
            REGISTRA:    proximo_estado = COMPARACAO;
            COMPARACAO: begin
                if (!chavesIgualMemoria) begin
                    proximo_estado = FIM_ERROU;
                end else if (fimC) begin
                    proximo_estado = FIM_ACERTOU;
                end else begin
                    proximo_estado = PROXIMO;
                end
            end
            PROXIMO:     proximo_estado = ESPERA;
            FIM_ACERTOU,
            FIM_TIMEOUT,
            FIM_ERROU:   if (iniciar) proximo_estado = PREPARACAO;
            default:     proximo_estado = INICIAL;
        endcase
    end

    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA:    registraR = 1'b1;
            PROXIMO:     contaC = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                timeout = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Bench for exp4_unidade_controle: emulates the datapath (address counter, compare plan) and
// checks game outcomes, strobe counts, timeout timing, key-hold behaviour and async reset.
module tb_exp4_unidade_controle;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic       chavesIgualMemoria;
    logic       fimC;
    logic       zeraC, contaC, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int checks   = 0;
    int failures = 0;

    // Datapath stand-in: address counter and per-address compare result.
    int  addr_cnt = 0;
    bit  plan_match [16];
    int  conta_pulses = 0;
    int  registra_pulses = 0;
    bit  noise = 0;

    exp4_unidade_controle #(.TIMEOUT_CICLOS(20)) dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .chaves             (chaves),
        .chavesIgualMemoria (chavesIgualMemoria),
        .fimC               (fimC),
        .zeraC              (zeraC),
        .contaC             (contaC),
        .zeraR              (zeraR),
        .registraR          (registraR),
        .pronto             (pronto),
        .acertou            (acertou),
        .errou              (errou),
        .timeout            (timeout),
        .db_estado          (db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (zeraC) addr_cnt <= 0;
        else if (contaC) addr_cnt <= addr_cnt + 1;
        if (contaC) conta_pulses <= conta_pulses + 1;
        if (registraR) registra_pulses <= registra_pulses + 1;
    end

    assign fimC = (addr_cnt == 15);
    assign chavesIgualMemoria = plan_match[addr_cnt % 16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (noise) iniciar = 1'($urandom % 2);
    endtask

    task automatic wait_state(input logic [3:0] code, input string tag);
        int n = 0;
        while (db_estado !== code && n < 40) begin
            tick();
            n++;
        end
        check(tag, {28'd0, db_estado}, {28'd0, code});
    endtask

    task automatic start_game(input string tag);
        iniciar = 1'b1;
        tick();
        check({tag, "_prep_state"}, {28'd0, db_estado}, 32'h1);
        check({tag, "_prep_zeras"}, {30'd0, zeraC, zeraR}, 32'h3);
        iniciar = 1'b0;
        tick();
        check({tag, "_espera_state"}, {28'd0, db_estado}, 32'h2);
        check({tag, "_espera_zeras"}, {30'd0, zeraC, zeraR}, 32'h0);
    endtask

    // k = index of the first mismatching play, 16 = all plays match.
    task automatic play_game(input int k, input string tag);
        int last;
        int base_c;
        int base_r;
        logic [3:0] exp_code;
        for (int i = 0; i < 16; i++) plan_match[i] = (i != k);
        last = (k < 16) ? k : 15;
        start_game(tag);
        base_c = conta_pulses;
        base_r = registra_pulses;
        noise = 1;
        for (int p = 0; p <= last; p++) begin
            repeat ($urandom_range(0, 6)) tick();
            chaves = 4'($urandom_range(1, 15));
            wait_state(4'h4, {tag, "_registra"});
            if (p == last) begin
                noise = 0;
                iniciar = 1'b0;
            end
            repeat ($urandom_range(0, 4)) tick();
            chaves = 4'h0;
            tick();
            tick();
            if (p != last) wait_state(4'h2, {tag, "_back_espera"});
        end
        exp_code = (k < 16) ? 4'hE : 4'hA;
        wait_state(exp_code, {tag, "_end"});
        repeat (3) tick();
        check({tag, "_end_hold"}, {28'd0, db_estado}, {28'd0, exp_code});
        check({tag, "_flags"}, {28'd0, pronto, acertou, errou, timeout},
              (k < 16) ? 32'b1010 : 32'b1100);
        check({tag, "_contaC"}, conta_pulses - base_c, (k < 16) ? k : 15);
        check({tag, "_registraR"}, registra_pulses - base_r, (k < 16) ? k + 1 : 16);
    endtask

    initial begin
        int base_r;
        reset   = 1'b0;
        iniciar = 1'b0;
        chaves  = 4'h0;
        for (int i = 0; i < 16; i++) plan_match[i] = 1'b1;

        repeat (3) tick();
        check("reset_state", {28'd0, db_estado}, 32'h0);
        check("reset_outputs", {24'd0, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}, 32'h0);
        reset = 1'b1;
        repeat (4) tick();
        check("idle_no_iniciar", {28'd0, db_estado}, 32'h0);

        play_game(2, "miss3");

        // Timeout measured from state E: entry into ESPERA must start from a cleared timer.
        start_game("to");
        repeat (19) tick();
        check("to_espera_20th", {28'd0, db_estado}, 32'h2);
        tick();
        check("to_state", {28'd0, db_estado}, 32'hD);
        check("to_flags", {28'd0, pronto, acertou, errou, timeout}, 32'b1011);

        play_game(16, "win");
        for (int g = 0; g < 3; g++) play_game(int'($urandom_range(0, 16)), "rand");

        // A key held for 50 cycles yields one play; the FSM then times out.
        for (int i = 0; i < 16; i++) plan_match[i] = 1'b1;
        start_game("hold");
        base_r = registra_pulses;
        chaves = 4'hF;
        repeat (50) tick();
        check("hold_one_pulse", registra_pulses - base_r, 1);
        check("hold_timeout", {28'd0, db_estado}, 32'hD);
        start_game("hold2");
        repeat (5) tick();
        check("hold_still_one", registra_pulses - base_r, 1);
        chaves = 4'h0;
        tick();
        tick();
        chaves = 4'h2;
        wait_state(4'h4, "repress_registra");
        chaves = 4'h0;
        tick();
        check("repress_pulse", registra_pulses - base_r, 2);
        wait_state(4'hD, "repress_timeout");

        // Asynchronous reset while sitting in COMPARACAO.
        start_game("rst");
        chaves = 4'h1;
        wait_state(4'h5, "rst_comparacao");
        chaves = 4'h0;
        reset = 1'b0;
        #1;
        check("rst_async_state", {28'd0, db_estado}, 32'h0);
        check("rst_async_outputs", {24'd0, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}, 32'h0);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check("rst_stays_inicial", {28'd0, db_estado}, 32'h0);
        iniciar = 1'b1;
        tick();
        check("rst_then_prep", {28'd0, db_estado}, 32'h1);
        iniciar = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
